mtm_alu_rsp_rx: RTL and testbench
=================================

# mtm_alu_rsp_rx

Serial response receiver for the mtm_Alu serial ALU. It sits directly downstream of the ALU's `sout` line and reassembles the frame stream into one parallel result word. It checks framing, the response CRC and error-frame parity. It presents each result on a single-entry valid/ready output register to the scoreboard or to system logic.

## Interface
- `NUM_DATA_FRAMES`, default 4: data frames preceding a normal CTL frame.
- `clk` input 1: posedge clock, same clock as the ALU.
- `rst_n` input 1: asynchronous active-low reset.
- `sin` input 1: serial line, driven by the ALU's `sout`. Idle state is high.
- `res_valid` output 1: a result is held in the output register.
- `res_ready` input 1: consumer accepts the result.
- `res_data` output 32: C, assembled MSB byte first.
- `res_flags` output 4: {carry, overflow, zero, negative}.
- `res_crc` output 3: received CRC field.
- `res_crc_ok` output 1: received CRC equals computed CRC.
- `res_err` output 1: result is an error frame.
- `res_err_flags` output 3: {ERR_DATA, ERR_CRC, ERR_OP}.
- `res_parity_ok` output 1: error-frame parity is correct.
- `frame_err` output 1: one-cycle pulse on a bad stop bit.
- `proto_err` output 1: one-cycle pulse on an illegal frame sequence.
- `overrun` output 1: one-cycle pulse when a completed result is dropped.

## Operation
- Frame format is 11 bits, one bit per clock:
  - start bit 0
  - type bit: 0 = DATA, 1 = CTL
  - 8 payload bits, MSB first
  - stop bit 1
- Bit FSM (`IDLE` → `TYPE` → `PAYLOAD` ×8 → `STOP` → `IDLE`):
  - `IDLE` leaves when `sin` is sampled 0.
  - `STOP` with `sin`=0 pulses `frame_err` and enters `RESYNC`.
  - `RESYNC` returns to `IDLE` on the first `sin`=1.
- Response FSM, with data counter `dcnt` 0..NUM_DATA_FRAMES:
  - DATA frame with `dcnt` < NUM_DATA_FRAMES: shift its byte into the C accumulator, increment `dcnt`.
  - DATA frame with `dcnt` = NUM_DATA_FRAMES: `proto_err`, clear `dcnt`.
  - CTL frame with payload[7]=0 and `dcnt` = NUM_DATA_FRAMES: normal result.
    - flags = payload[6:3], crc = payload[2:0].
    - Computed CRC: CRC-3, polynomial x³+x+1, init 0, over the 37 bits {C[31:0], 1'b0, flags}, MSB first.
  - CTL frame with payload[7]=1 and `dcnt` = 0: error result.
    - `res_err_flags` = payload[6:4].
    - `res_parity_ok` = (^payload[7:1] == payload[0]) AND (payload[6:4] == payload[3:1]).
  - Any other CTL frame: `proto_err`, no result.
  - `dcnt` clears after every CTL frame and after every `frame_err`.
  - `frame_err` discards the partially assembled response.
- Output register:
  - A completed result loads only when `res_valid`=0, or when `res_valid`=1 and `res_ready`=1 in the same cycle.
  - Otherwise the new result is dropped, `overrun` pulses, and the held result stays unchanged.
  - The serial line cannot be backpressured; reception never stalls.
- Unused fields: `res_data`/`res_flags`/`res_crc`/`res_crc_ok` read 0 for error results; `res_err_flags`/`res_parity_ok` read 0 for normal results.

## Timing
- Reset values:
  - All outputs 0.
  - Both FSMs in `IDLE`, `dcnt` = 0, accumulators cleared.
- Reset asserted mid-frame aborts the frame with no pulses. The first start bit after release begins a fresh response.
- The stop bit of the CTL frame is sampled at edge N; `res_valid` is 1 from edge N+1.
- A normal response is 55 line cycles. An error response is 11 cycles.
- Handshake: the output transfers on an edge with `res_valid` && `res_ready`. `res_valid` falls on the next edge unless a result loads on that same edge.
- Error pulses are registered, 1 cycle after the offending stop-bit sample.
- Back-to-back frames: a start bit immediately after a stop bit is accepted with no idle gap.

## Structure
- Package `mtm_alu_rx_pkg` holds:
  - `frame_type_t` enum {DATA, CTL}
  - bit-FSM and response-FSM state enums
  - `FRAME_BITS` = 11
  - function `crc3_37` (37-bit data → 3-bit CRC)
  - typedef `alu_result_t` packed struct holding the output fields
- Sub-module `mtm_alu_frame_rx` contains the bit FSM. It outputs `byte_valid` (1-cycle), `byte_type`, `byte_data[7:0]` and `frame_err`.
- `mtm_alu_rsp_rx` contains the response FSM, the CRC/parity check and the output register.

## Test plan
- Normal response: C = 0x12345678, flags = 4'b0000, correct CRC, `res_ready`=1 → one `res_valid` pulse, `res_data` = 0x12345678, `res_crc_ok` = 1, `res_err` = 0.
- Same response with CRC bit 0 inverted → `res_crc_ok` = 0, all other fields unchanged.
- Error CTL frame 0xC9 → `res_err` = 1, `res_err_flags` = 3'b100, `res_parity_ok` = 1. Payload 0xC8 → `res_parity_ok` = 0.
- Stop bit 0 on the 2nd data frame, then a valid full response → `frame_err` pulses once, then the correct second result appears.
- Normal CTL frame after 2 data frames → `proto_err` pulses, no `res_valid`. A fifth DATA frame → `proto_err` pulses.
- `res_ready` = 0 across two complete responses → first result held, `overrun` pulses once at the second response's CTL stop bit. `rst_n` low mid-frame → all outputs 0 immediately.

Source files
------------

// File: rtl/mtm_alu_rx_pkg.sv
// rtl/mtm_alu_rx_pkg.sv - shared types, frame constants and CRC-3 helper for the mtm_Alu response receiver
package mtm_alu_rx_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic {
    DATA = 1'b0,
    CTL  = 1'b1
  } frame_type_t;

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_TYPE,
    BIT_PAYLOAD,
    BIT_STOP,
    BIT_RESYNC
  } bit_state_t;

  typedef enum logic {
    RSP_IDLE,
    RSP_DATA
  } rsp_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic        crc_ok;
    logic        err;
    logic [2:0]  err_flags;
    logic        parity_ok;
  } alu_result_t;

  // x^3+x+1, init 0, MSB first
  function automatic logic [2:0] crc3_37(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = d[i] ^ c[2];
      c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return c;
  endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// rtl/mtm_alu_frame_rx.sv - bit-level FSM turning the serial line into typed bytes
module mtm_alu_frame_rx
  import mtm_alu_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        byte_valid,
  output frame_type_t byte_type,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int PAYLOAD_BITS = FRAME_BITS - 3;

  bit_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BIT_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_type  <= DATA;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        BIT_IDLE: begin
          if (!sin) state <= BIT_TYPE;
        end
        BIT_TYPE: begin
          byte_type <= frame_type_t'(sin);
          bit_cnt   <= '0;
          state     <= BIT_PAYLOAD;
        end
        BIT_PAYLOAD: begin
          shreg <= {shreg[6:0], sin};
          if (bit_cnt == 3'(PAYLOAD_BITS - 1)) state <= BIT_STOP;
          else bit_cnt <= bit_cnt + 3'd1;
        end
        BIT_STOP: begin
          // Returning straight to IDLE lets a start bit follow the stop bit with no gap
          if (sin) begin
            byte_valid <= 1'b1;
            byte_data  <= shreg;
            state      <= BIT_IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= BIT_RESYNC;
          end
        end
        BIT_RESYNC: begin
          if (sin) state <= BIT_IDLE;
        end
        default: state <= BIT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mtm_alu_rsp_rx.sv
// rtl/mtm_alu_rsp_rx.sv - mtm_Alu response receiver: frame sequencing, CRC/parity check, valid/ready result register
module mtm_alu_rsp_rx
  import mtm_alu_rx_pkg::*;
#(
  parameter int NUM_DATA_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_flags,
  output logic [2:0]  res_crc,
  output logic        res_crc_ok,
  output logic        res_err,
  output logic [2:0]  res_err_flags,
  output logic        res_parity_ok,
  output logic        frame_err,
  output logic        proto_err,
  output logic        overrun
);

  localparam int              DW        = $clog2(NUM_DATA_FRAMES + 1);
  localparam logic [DW-1:0]   DCNT_FULL = DW'(NUM_DATA_FRAMES);

  logic        byte_valid;
  frame_type_t byte_type;
  logic [7:0]  byte_data;
  logic        fr_err;

  rsp_state_t  rsp_state;
  logic [DW-1:0] dcnt;
  logic [31:0] c_acc;

  alu_result_t res_q;
  alu_result_t new_res;
  logic        new_valid;
  logic        new_proto;

  mtm_alu_frame_rx u_frame_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .byte_valid (byte_valid),
    .byte_type  (byte_type),
    .byte_data  (byte_data),
    .frame_err  (fr_err)
  );

  always_comb begin
    new_res   = '0;
    new_valid = 1'b0;
    new_proto = 1'b0;
    if (byte_valid) begin
      if (byte_type == DATA) begin
        if (dcnt == DCNT_FULL) new_proto = 1'b1;
      end else if (!byte_data[7] && dcnt == DCNT_FULL) begin
        new_valid      = 1'b1;
        new_res.data   = c_acc;
        new_res.flags  = byte_data[6:3];
        new_res.crc    = byte_data[2:0];
        new_res.crc_ok = (crc3_37({c_acc, 1'b0, byte_data[6:3]}) == byte_data[2:0]);
      end else if (byte_data[7] && rsp_state == RSP_IDLE) begin
        // Error frames carry the flags twice plus odd-free parity over bits 7..1
        new_valid         = 1'b1;
        new_res.err       = 1'b1;
        new_res.err_flags = byte_data[6:4];
        new_res.parity_ok = ((^byte_data[7:1]) == byte_data[0]) &&
                            (byte_data[6:4] == byte_data[3:1]);
      end else begin
        new_proto = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_state <= RSP_IDLE;
      dcnt      <= '0;
      c_acc     <= '0;
    end else if (fr_err) begin
      rsp_state <= RSP_IDLE;
      dcnt      <= '0;
      c_acc     <= '0;
    end else if (byte_valid) begin
      if (byte_type == DATA && dcnt != DCNT_FULL) begin
        c_acc     <= {c_acc[23:0], byte_data};
        dcnt      <= dcnt + 1'b1;
        rsp_state <= RSP_DATA;
      end else begin
        c_acc     <= '0;
        dcnt      <= '0;
        rsp_state <= RSP_IDLE;
      end
    end
  end

  // The line cannot be stalled, so a result with nowhere to go is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_q     <= '0;
      proto_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      proto_err <= new_proto;
      overrun   <= 1'b0;
      if (new_valid) begin
        if (!res_valid || res_ready) begin
          res_q     <= new_res;
          res_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign res_data      = res_q.data;
  assign res_flags     = res_q.flags;
  assign res_crc       = res_q.crc;
  assign res_crc_ok    = res_q.crc_ok;
  assign res_err       = res_q.err;
  assign res_err_flags = res_q.err_flags;
  assign res_parity_ok = res_q.parity_ok;
  assign frame_err     = fr_err;

endmodule

// File: tb/tb_mtm_alu_rsp_rx.sv
// tb/tb_mtm_alu_rsp_rx.sv - directed self-checking bench for mtm_alu_rsp_rx
module tb_mtm_alu_rsp_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic        res_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic [2:0]  res_crc;
  logic        res_crc_ok;
  logic        res_err;
  logic [2:0]  res_err_flags;
  logic        res_parity_ok;
  logic        frame_err;
  logic        proto_err;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;

  int cnt_frame_err = 0;
  int cnt_proto     = 0;
  int cnt_overrun   = 0;
  int cnt_xfer      = 0;
  logic [31:0] cap_data      = '0;
  logic [3:0]  cap_flags     = '0;
  logic [2:0]  cap_crc       = '0;
  logic        cap_crc_ok    = 1'b0;
  logic        cap_err       = 1'b0;
  logic [2:0]  cap_err_flags = '0;
  logic        cap_parity_ok = 1'b0;

  mtm_alu_rsp_rx #(.NUM_DATA_FRAMES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sin           (sin),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_flags     (res_flags),
    .res_crc       (res_crc),
    .res_crc_ok    (res_crc_ok),
    .res_err       (res_err),
    .res_err_flags (res_err_flags),
    .res_parity_ok (res_parity_ok),
    .frame_err     (frame_err),
    .proto_err     (proto_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) cnt_frame_err++;
    if (proto_err) cnt_proto++;
    if (overrun)   cnt_overrun++;
    if (res_valid && res_ready) begin
      cnt_xfer++;
      cap_data      = res_data;
      cap_flags     = res_flags;
      cap_crc       = res_crc;
      cap_crc_ok    = res_crc_ok;
      cap_err       = res_err;
      cap_err_flags = res_err_flags;
      cap_parity_ok = res_parity_ok;
    end
  end

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic t, input logic [7:0] b, input logic stop);
    logic [10:0] f;
    f = {1'b0, t, b, stop};
    for (int i = 10; i >= 0; i--) begin
      sin = f[i];
      @(negedge clk);
    end
  endtask

  task automatic send_data4(input logic [31:0] c);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, c[i*8 +: 8], 1'b1);
  endtask

  task automatic test_reset();
    n_tests++;
    if (res_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %b expected 0", res_valid); n_fail++;
    end
    n_tests++;
    if (res_data !== 32'h0) begin
      $display("FAIL reset_data: got %h expected 00000000", res_data); n_fail++;
    end
    n_tests++;
    if ({res_flags, res_crc, res_crc_ok, res_err, res_err_flags, res_parity_ok} !== 14'h0) begin
      $display("FAIL reset_fields: got %h expected 0000",
               {res_flags, res_crc, res_crc_ok, res_err, res_err_flags, res_parity_ok}); n_fail++;
    end
    n_tests++;
    if ({frame_err, proto_err, overrun} !== 3'b000) begin
      $display("FAIL reset_pulses: got %b expected 000", {frame_err, proto_err, overrun}); n_fail++;
    end
  endtask

  task automatic test_normal();
    int x0, p0, f0;
    x0 = cnt_xfer; p0 = cnt_proto; f0 = cnt_frame_err;
    send_data4(32'h12345678);
    send_frame(1'b1, 8'h06, 1'b1);
    n_tests++;
    if (res_valid !== 1'b0) begin
      $display("FAIL normal_latency_early: got %b expected 0", res_valid); n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1) begin
      $display("FAIL normal_latency_valid: got %b expected 1", res_valid); n_fail++;
    end
    idle(3);
    n_tests++;
    if (cnt_xfer - x0 !== 1) begin
      $display("FAIL normal_xfers: got %0d expected 1", cnt_xfer - x0); n_fail++;
    end
    n_tests++;
    if (cap_data !== 32'h12345678) begin
      $display("FAIL normal_data: got %h expected 12345678", cap_data); n_fail++;
    end
    n_tests++;
    if ({cap_flags, cap_crc, cap_crc_ok, cap_err} !== {4'b0000, 3'b110, 1'b1, 1'b0}) begin
      $display("FAIL normal_fields: got flags=%b crc=%b ok=%b err=%b expected 0000 110 1 0",
               cap_flags, cap_crc, cap_crc_ok, cap_err); n_fail++;
    end
    n_tests++;
    if ((cnt_proto - p0) + (cnt_frame_err - f0) !== 0 || res_valid !== 1'b0) begin
      $display("FAIL normal_clean: got err pulses=%0d valid=%b expected 0 0",
               (cnt_proto - p0) + (cnt_frame_err - f0), res_valid); n_fail++;
    end
  endtask

  task automatic test_bad_crc();
    int x0;
    x0 = cnt_xfer;
    send_data4(32'h12345678);
    send_frame(1'b1, 8'h07, 1'b1);
    idle(3);
    n_tests++;
    if (cnt_xfer - x0 !== 1) begin
      $display("FAIL badcrc_xfers: got %0d expected 1", cnt_xfer - x0); n_fail++;
    end
    n_tests++;
    if (cap_crc_ok !== 1'b0) begin
      $display("FAIL badcrc_ok: got %b expected 0", cap_crc_ok); n_fail++;
    end
    n_tests++;
    if ({cap_data, cap_flags, cap_crc, cap_err} !== {32'h12345678, 4'b0000, 3'b111, 1'b0}) begin
      $display("FAIL badcrc_fields: got %h %b %b %b expected 12345678 0000 111 0",
               cap_data, cap_flags, cap_crc, cap_err); n_fail++;
    end
  endtask

  task automatic test_error_frame();
    send_frame(1'b1, 8'hC9, 1'b1);
    idle(3);
    n_tests++;
    if ({cap_err, cap_err_flags, cap_parity_ok} !== 5'b1_100_1) begin
      $display("FAIL errframe_c9: got err=%b flags=%b par=%b expected 1 100 1",
               cap_err, cap_err_flags, cap_parity_ok); n_fail++;
    end
    n_tests++;
    if ({cap_data, cap_flags, cap_crc, cap_crc_ok} !== 40'h0) begin
      $display("FAIL errframe_unused: got %h expected 0", {cap_data, cap_flags, cap_crc, cap_crc_ok}); n_fail++;
    end
    send_frame(1'b1, 8'hC8, 1'b1);
    idle(3);
    n_tests++;
    if ({cap_err, cap_err_flags, cap_parity_ok} !== 5'b1_100_0) begin
      $display("FAIL errframe_c8: got err=%b flags=%b par=%b expected 1 100 0",
               cap_err, cap_err_flags, cap_parity_ok); n_fail++;
    end
  endtask

  task automatic test_frame_err();
    int x0, f0, p0;
    x0 = cnt_xfer; f0 = cnt_frame_err; p0 = cnt_proto;
    send_frame(1'b0, 8'hAA, 1'b1);
    send_frame(1'b0, 8'hBB, 1'b0);
    idle(2);
    send_data4(32'h12345678);
    send_frame(1'b1, 8'h55, 1'b1);
    idle(3);
    n_tests++;
    if (cnt_frame_err - f0 !== 1) begin
      $display("FAIL frameerr_pulses: got %0d expected 1", cnt_frame_err - f0); n_fail++;
    end
    n_tests++;
    if (cnt_xfer - x0 !== 1 || cnt_proto - p0 !== 0) begin
      $display("FAIL frameerr_recover: got xfers=%0d proto=%0d expected 1 0",
               cnt_xfer - x0, cnt_proto - p0); n_fail++;
    end
    n_tests++;
    if ({cap_data, cap_flags, cap_crc, cap_crc_ok} !== {32'h12345678, 4'b1010, 3'b101, 1'b1}) begin
      $display("FAIL frameerr_result: got %h %b %b %b expected 12345678 1010 101 1",
               cap_data, cap_flags, cap_crc, cap_crc_ok); n_fail++;
    end
  endtask

  task automatic test_proto_err();
    int x0, p0;
    x0 = cnt_xfer; p0 = cnt_proto;
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b1, 8'h06, 1'b1);
    idle(3);
    n_tests++;
    if (cnt_proto - p0 !== 1 || cnt_xfer - x0 !== 0) begin
      $display("FAIL proto_short: got proto=%0d xfers=%0d expected 1 0", cnt_proto - p0, cnt_xfer - x0); n_fail++;
    end
    p0 = cnt_proto;
    send_data4(32'hCAFEF00D);
    send_frame(1'b0, 8'h33, 1'b1);
    idle(3);
    n_tests++;
    if (cnt_proto - p0 !== 1 || cnt_xfer - x0 !== 0) begin
      $display("FAIL proto_fifth: got proto=%0d xfers=%0d expected 1 0", cnt_proto - p0, cnt_xfer - x0); n_fail++;
    end
  endtask

  task automatic test_overrun();
    int x0, o0;
    res_ready = 1'b0;
    x0 = cnt_xfer; o0 = cnt_overrun;
    send_data4(32'h12345678);
    send_frame(1'b1, 8'h06, 1'b1);
    idle(2);
    send_data4(32'h12345678);
    send_frame(1'b1, 8'h55, 1'b1);
    idle(3);
    n_tests++;
    if (cnt_overrun - o0 !== 1) begin
      $display("FAIL overrun_pulses: got %0d expected 1", cnt_overrun - o0); n_fail++;
    end
    n_tests++;
    if ({res_valid, res_flags, res_crc, res_crc_ok} !== {1'b1, 4'b0000, 3'b110, 1'b1}) begin
      $display("FAIL overrun_held: got %b %b %b %b expected 1 0000 110 1",
               res_valid, res_flags, res_crc, res_crc_ok); n_fail++;
    end
    @(posedge clk);
    #2 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (cnt_xfer - x0 !== 1 || cap_flags !== 4'b0000 || res_valid !== 1'b0) begin
      $display("FAIL overrun_drain: got xfers=%0d flags=%b valid=%b expected 1 0000 0",
               cnt_xfer - x0, cap_flags, res_valid); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int x0, p0;
    x0 = cnt_xfer; p0 = cnt_proto;
    send_frame(1'b1, 8'hC9, 1'b1);
    send_frame(1'b1, 8'hC8, 1'b1);
    idle(3);
    n_tests++;
    if (cnt_xfer - x0 !== 2 || cnt_proto - p0 !== 0 || cap_parity_ok !== 1'b0) begin
      $display("FAIL b2b: got xfers=%0d proto=%0d par=%b expected 2 0 0",
               cnt_xfer - x0, cnt_proto - p0, cap_parity_ok); n_fail++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int x0, p0, f0;
    logic [4:0] partial;
    res_ready = 1'b0;
    send_frame(1'b1, 8'hC9, 1'b1);
    idle(2);
    n_tests++;
    if (res_valid !== 1'b1) begin
      $display("FAIL midreset_pre: got %b expected 1", res_valid); n_fail++;
    end
    partial = 5'b00101;
    for (int i = 4; i >= 0; i--) begin
      sin = partial[i];
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({res_valid, res_err, res_err_flags, res_parity_ok, res_data} !== 38'h0) begin
      $display("FAIL midreset_outputs: got %h expected 0",
               {res_valid, res_err, res_err_flags, res_parity_ok, res_data}); n_fail++;
    end
    sin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    x0 = cnt_xfer; p0 = cnt_proto; f0 = cnt_frame_err;
    idle(2);
    send_data4(32'h12345678);
    send_frame(1'b1, 8'h06, 1'b1);
    idle(3);
    n_tests++;
    if (cnt_xfer - x0 !== 1 || cap_data !== 32'h12345678 || cap_crc_ok !== 1'b1) begin
      $display("FAIL midreset_fresh: got xfers=%0d data=%h ok=%b expected 1 12345678 1",
               cnt_xfer - x0, cap_data, cap_crc_ok); n_fail++;
    end
    n_tests++;
    if ((cnt_proto - p0) + (cnt_frame_err - f0) !== 0) begin
      $display("FAIL midreset_pulses: got %0d expected 0", (cnt_proto - p0) + (cnt_frame_err - f0)); n_fail++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sin       = 1'b1;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_normal();
    test_bad_crc();
    test_error_frame();
    test_frame_err();
    test_proto_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
